// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache and its main-memory controller.
// Holds the address/data geometry, the controller FSM state type and
// the power-on contents pattern of the backing store.
package dcache_pkg;

    localparam int ADDR_W   = 17;
    localparam int OFFSET_W = 4;
    localparam int DATA_W   = 32;
    localparam int LINE_W   = ADDR_W - OFFSET_W;
    localparam int BEATS    = 2 ** OFFSET_W;

    localparam logic [DATA_W-1:0] INIT_BASE = 32'hC000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_BURST,
        WR_BURST,
        WR_DONE
    } state_t;

    // Power-on contents of word address a.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return INIT_BASE | DATA_W'(a);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port 2**ADDR_W x DATA_W word store with synchronous read.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (clears rdata, blocks writes)
//   en     in   port enable for this cycle
//   we     in   1 = write wdata to addr, 0 = read addr into rdata
//   addr   in   ADDR_W word address
//   wdata  in   DATA_W write data
//   rdata  out  DATA_W registered read data
// The store keeps each word XOR-ed with its power-on pattern, so an array
// that powers up all-zero presents init_word(a) at every address without
// any preload, and a reset never disturbs the contents.
module mem_line_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] store [DEPTH];

    // A write landing on a reset edge is dropped so an aborted burst
    // leaves only the beats committed before the reset.
    always_ff @(posedge clk) begin
        if (rst_n && en && we) begin
            store[addr] <= wdata ^ init_word(addr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= store[addr] ^ init_word(addr);
        end
    end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Line-granular main-memory controller serving the dcache: 16-beat fill
// read bursts and 16-beat writeback bursts, one transaction at a time,
// with a programmable access latency.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake; req_write selects writeback
//   req_line            line address {tag,index}
//   rd_valid/data/beat  registered read beats, no backpressure
//   rd_last             marks beat 15
//   wr_valid/ready/data write beat handshake; wr_valid=0 stalls the burst
//   wr_done             one-cycle pulse once all 16 words are written
module dcache_mem_ctrl
    import dcache_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [LINE_W-1:0]   req_line,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [OFFSET_W-1:0] rd_beat,
    output logic                rd_last,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_done
);

    localparam int LAT_W = $clog2(LATENCY + 1);

    state_t              state;
    state_t              next_state;
    logic [LINE_W-1:0]   cur_line;
    logic                cur_write;
    logic [OFFSET_W-1:0] beat;
    logic [LAT_W-1:0]    lat_cnt;

    logic                accept;
    logic                wait_done;
    logic                last_beat;
    logic                rd_issue;
    logic                wr_beat;
    logic [OFFSET_W-1:0] mem_offset;

    assign accept    = req_valid && (state == IDLE);
    assign wait_done = (state == WAIT) && (lat_cnt == '0);
    assign last_beat = (beat == OFFSET_W'(BEATS - 1));
    assign wr_beat   = (state == WR_BURST) && wr_valid;

    // The array read register is the rd_data register, so each beat is
    // fetched on the edge that makes it visible: beat 0 on the edge that
    // leaves WAIT, beat k+1 on the edge after beat k is presented.
    assign rd_issue   = (wait_done && !cur_write) || ((state == RD_BURST) && !last_beat);
    assign mem_offset = (state == WR_BURST) ? beat :
                        (state == WAIT)     ? '0   : beat + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept)               next_state = WAIT;
            WAIT:     if (lat_cnt == '0)        next_state = cur_write ? WR_BURST : RD_BURST;
            RD_BURST: if (last_beat)            next_state = IDLE;
            WR_BURST: if (wr_valid && last_beat) next_state = WR_DONE;
            WR_DONE:                            next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    // All outputs decode the state register, so they change only on edges.
    always_comb begin
        req_ready = (state == IDLE);
        rd_valid  = (state == RD_BURST);
        rd_last   = (state == RD_BURST) && last_beat;
        rd_beat   = (state == RD_BURST) ? beat : '0;
        wr_ready  = (state == WR_BURST);
        wr_done   = (state == WR_DONE);
    end

    // WAIT spends LATENCY cycles counting LATENCY-1 down to 0. The beat
    // counter wraps 15->0 exactly on the edge that leaves a burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_line  <= '0;
            cur_write <= 1'b0;
            beat      <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_line  <= req_line;
                        cur_write <= req_write;
                        lat_cnt   <= LAT_W'(LATENCY - 1);
                        beat      <= '0;
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RD_BURST: beat <= beat + 1'b1;
                WR_BURST: begin
                    if (wr_valid) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_line_array u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_issue || wr_beat),
        .we    (wr_beat),
        .addr  ({cur_line, mem_offset}),
        .wdata (wr_data),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Scoreboard bench for dcache_mem_ctrl: two instances (LATENCY 4 and 1)
// share one stimulus set, routed by 'sel'. Fills push their expected
// beats (data, offset, arrival cycle) from a word-level memory model;
// a negedge monitor pops and compares every beat and wr_done pulse.
module tb_dcache_mem_ctrl;
    import dcache_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                beat;
        int                cyc;
    } rd_exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sel = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_write = 1'b0;
    logic [LINE_W-1:0]   req_line = '0;
    logic                wr_valid = 1'b0;
    logic [DATA_W-1:0]   wr_data = '0;

    logic                req_ready4, rd_valid4, rd_last4, wr_ready4, wr_done4;
    logic [DATA_W-1:0]   rd_data4;
    logic [OFFSET_W-1:0] rd_beat4;
    logic                req_ready1, rd_valid1, rd_last1, wr_ready1, wr_done1;
    logic [DATA_W-1:0]   rd_data1;
    logic [OFFSET_W-1:0] rd_beat1;

    logic                req_ready_m, rd_valid_m, rd_last_m, wr_ready_m, wr_done_m;
    logic [DATA_W-1:0]   rd_data_m;
    logic [OFFSET_W-1:0] rd_beat_m;

    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;
    int                  done_pending = 0;
    rd_exp_t             rd_q[$];
    logic [DATA_W-1:0]   model_mem [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign req_ready_m = sel ? req_ready1 : req_ready4;
    assign rd_valid_m  = sel ? rd_valid1  : rd_valid4;
    assign rd_last_m   = sel ? rd_last1   : rd_last4;
    assign wr_ready_m  = sel ? wr_ready1  : wr_ready4;
    assign wr_done_m   = sel ? wr_done1   : wr_done4;
    assign rd_data_m   = sel ? rd_data1   : rd_data4;
    assign rd_beat_m   = sel ? rd_beat1   : rd_beat4;

    dcache_mem_ctrl #(.LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(req_ready4),
        .req_write(req_write), .req_line(req_line),
        .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_beat(rd_beat4), .rd_last(rd_last4),
        .wr_valid(wr_valid && !sel), .wr_ready(wr_ready4), .wr_data(wr_data),
        .wr_done(wr_done4)
    );

    dcache_mem_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(req_ready1),
        .req_write(req_write), .req_line(req_line),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_beat(rd_beat1), .rd_last(rd_last1),
        .wr_valid(wr_valid && sel), .wr_ready(wr_ready1), .wr_data(wr_data),
        .wr_done(wr_done1)
    );

    function automatic int cur_lat();
        return sel ? 1 : 4;
    endfunction

    function automatic int model_key(input logic [LINE_W-1:0] line, input int k);
        return (sel ? 131072 : 0) + int'(line) * 16 + k;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [LINE_W-1:0] line, input int k);
        int key;
        key = model_key(line, k);
        if (model_mem.exists(key)) return model_mem[key];
        return 32'hC000_0000 | 32'(int'(line) * 16 + k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [LINE_W-1:0] line);
        req_valid = valid;
        req_write = write;
        req_line  = line;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until it is accepted; returns the acceptance edge.
    task automatic issueRequest(input logic write, input logic [LINE_W-1:0] line, output int acc);
        logic rr;
        acc = -1;
        applyStimulus(1'b1, write, line);
        for (int w = 0; w < 200; w++) begin
            rr = req_ready_m;
            step();
            if (rr) begin
                acc = cyc;
                break;
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        if (acc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no acceptance expected one within 200 cycles");
        end else if (!write) begin
            for (int k = 0; k < BEATS; k++) begin
                rd_q.push_back('{data: model_read(line, k), beat: k, cyc: acc + cur_lat() + k});
            end
        end
    endtask

    task automatic finishFill(input int acc);
        while (cyc < acc + cur_lat() + 15) step();
        checkOutput("req_ready_busy", 32'(req_ready_m), 32'd0);
        step();
        checkOutput("req_ready_after", 32'(req_ready_m), 32'd1);
    endtask

    task automatic doFill(input logic [LINE_W-1:0] line);
        int acc;
        issueRequest(1'b0, line, acc);
        if (acc >= 0) finishFill(acc);
    endtask

    task automatic doWriteback(input logic [LINE_W-1:0] line, input int stall_at, input int stall_len,
                               input int abort_at, input bit rand_data, input logic [31:0] base);
        int acc;
        logic [DATA_W-1:0] d;
        issueRequest(1'b1, line, acc);
        if (acc < 0) return;
        while (cyc < acc + cur_lat() - 1) step();
        checkOutput("wr_ready_early", 32'(wr_ready_m), 32'd0);
        step();
        checkOutput("wr_ready_first", 32'(wr_ready_m), 32'd1);
        for (int k = 0; k < BEATS; k++) begin
            d = rand_data ? $urandom : base + 32'(k);
            if (k == abort_at) begin
                rst_n = 1'b0;
                wr_valid = 1'b1;
                wr_data = d;
                step();
                rst_n = 1'b1;
                wr_valid = 1'b0;
                checkOutput("abort_wr_ready", 32'(wr_ready_m), 32'd0);
                checkOutput("abort_req_ready", 32'(req_ready_m), 32'd1);
                return;
            end
            checkOutput("wr_ready_beat", 32'(wr_ready_m), 32'd1);
            wr_valid = 1'b1;
            wr_data = d;
            if (k == BEATS - 1) done_pending++;
            step();
            model_mem[model_key(line, k)] = d;
            if (k == stall_at && k != BEATS - 1) begin
                for (int s = 0; s < stall_len; s++) begin
                    wr_valid = 1'b0;
                    wr_data = 32'hDEAD_BEEF;
                    checkOutput("wr_ready_stall", 32'(wr_ready_m), 32'd1);
                    step();
                end
            end
        end
        wr_valid = 1'b0;
        checkOutput("wr_ready_done", 32'(wr_ready_m), 32'd0);
        step();
        checkOutput("wr_done_seen", 32'(done_pending), 32'd0);
    endtask

    // Monitor: compares every presented beat and wr_done pulse.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (rd_valid_m) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got beat %0d data %h expected no beat", rd_beat_m, rd_data_m);
            end else begin
                e = rd_q.pop_front();
                checkOutput("rd_data", rd_data_m, e.data);
                checkOutput("rd_beat", 32'(rd_beat_m), 32'(e.beat));
                checkOutput("rd_last", 32'(rd_last_m), 32'(e.beat == 15));
                checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rd_last_m) begin
            checkOutput("rd_last_idle", 32'(rd_last_m), 32'd0);
        end
        if (wr_done_m) begin
            checks++;
            if (done_pending == 0) begin
                errors++;
                $display("[TB] FAIL wr_done_extra: got pulse expected none");
            end else begin
                done_pending--;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int acc_a;
        int acc_b;
        logic [LINE_W-1:0] line;
        logic [LINE_W-1:0] pool [4];

        repeat (3) step();
        checkOutput("rst_req_ready", 32'(req_ready4), 32'd1);
        checkOutput("rst_rd_valid", 32'(rd_valid4), 32'd0);
        checkOutput("rst_rd_last", 32'(rd_last4), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready4), 32'd0);
        checkOutput("rst_wr_done", 32'(wr_done4), 32'd0);
        checkOutput("rst_rd_data", rd_data4, 32'd0);
        checkOutput("rst_rd_beat", 32'(rd_beat4), 32'd0);
        checkOutput("rst1_req_ready", 32'(req_ready1), 32'd1);
        checkOutput("rst1_rd_valid", 32'(rd_valid1), 32'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] fill at LATENCY=4");
        doFill(13'h1380);

        $display("[TB] writeback with stall, then fill");
        doWriteback(13'h1780, 6, 3, -1, 1'b0, 32'hAAAA_0000);
        doFill(13'h1780);

        $display("[TB] request held while busy");
        issueRequest(1'b0, 13'h1380, acc_a);
        issueRequest(1'b0, 13'h0042, acc_b);
        checkOutput("busy_accept_cycle", 32'(acc_b), 32'(acc_a + 4 + 17));
        finishFill(acc_b);

        $display("[TB] reset during read beat 7");
        issueRequest(1'b0, 13'h1380, acc_a);
        while (cyc < acc_a + 4 + 7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd_q.delete();
        checkOutput("mid_rst_rd_valid", 32'(rd_valid_m), 32'd0);
        checkOutput("mid_rst_rd_last", 32'(rd_last_m), 32'd0);
        checkOutput("mid_rst_req_ready", 32'(req_ready_m), 32'd1);
        checkOutput("mid_rst_rd_data", rd_data_m, 32'd0);
        doFill(13'h0000);

        $display("[TB] reset during write beat 5");
        doWriteback(13'h0AAA, -1, 0, 5, 1'b1, 32'h0);
        doFill(13'h0AAA);

        $display("[TB] LATENCY=1 instance");
        sel = 1'b1;
        step();
        doFill(13'($urandom));
        doWriteback(13'h1780, 3, 2, -1, 1'b1, 32'h0);
        doFill(13'h1780);
        sel = 1'b0;
        step();

        $display("[TB] stray write beats in IDLE and WAIT");
        wr_valid = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        repeat (3) step();
        issueRequest(1'b0, 13'h0555, acc_a);
        finishFill(acc_a);
        wr_valid = 1'b0;
        doFill(13'h0555);

        $display("[TB] randomized traffic");
        pool[0] = 13'h1780;
        pool[1] = 13'h1380;
        pool[2] = 13'h0000;
        pool[3] = 13'h1FFF;
        for (int n = 0; n < 24; n++) begin
            sel = 1'($urandom_range(0, 1));
            step();
            line = ($urandom_range(0, 4) == 4) ? 13'($urandom) : pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) begin
                doWriteback(line, $urandom_range(0, 15), $urandom_range(0, 3), -1, 1'b1, 32'h0);
            end else begin
                doFill(line);
            end
        end
        sel = 1'b0;

        for (int w = 0; w < 100 && rd_q.size() != 0; w++) step();
        checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("wr_done_drained", 32'(done_pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
